// File: rtl/instr_register_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_register_queue
// Brief    : FIFO-ordered instruction store with show-ahead head and peek port.
//            Optional drop counter enabled by macro INSTR_REG_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_register_queue #(
  parameter int OPC_W = 4,
  parameter int OPD_W = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset_en,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [OPC_W-1:0]         wr_opcode,
  input  logic [OPD_W-1:0]         wr_operand_a,
  input  logic [OPD_W-1:0]         wr_operand_b,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [OPC_W+2*OPD_W-1:0] rd_instr,
  input  logic [IDX_W-1:0]         peek_index,
  output logic [OPC_W+2*OPD_W-1:0] peek_instr,
  output logic                     peek_valid,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
`ifdef INSTR_REG_DROP_CNT_EN
  output logic [15:0]              drop_count,
`endif
  output logic                     empty
);

  localparam int INSTR_W = OPC_W + 2*OPD_W;
  localparam logic [IDX_W-1:0] c_last_ptr  = IDX_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [IDX_W:0]   c_depth_mod = (IDX_W+1)'(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]   r_wr_ptr;
  logic [IDX_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [IDX_W:0]     w_peek_sum;
  logic [IDX_W-1:0]   w_peek_ptr;

  assign full     = (r_count == c_depth_cnt);
  assign empty    = (r_count == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign count    = r_count;

  assign w_push = wr_valid && wr_ready;
  assign w_pop  = rd_valid && rd_ready;

  // Modulo on a one-bit-wider sum keeps the wrap correct for any DEPTH.
  assign w_peek_sum = {1'b0, r_rd_ptr} + {1'b0, peek_index};
  assign w_peek_ptr = IDX_W'(w_peek_sum % c_depth_mod);

  assign rd_instr   = r_mem[r_rd_ptr];
  assign peek_instr = r_mem[w_peek_ptr];
  assign peek_valid = (CNT_W'(peek_index) < r_count);

  always_ff @(posedge clk or posedge reset_en) begin
    if (reset_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {wr_opcode, wr_operand_a, wr_operand_b};
    end
  end

  always_ff @(posedge clk or posedge reset_en) begin
    if (reset_en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef INSTR_REG_DROP_CNT_EN
  logic [15:0] r_drop_count;

  // Counts rejected push attempts; survives flush so overflow history is kept.
  always_ff @(posedge clk or posedge reset_en) begin
    if (reset_en) begin
      r_drop_count <= '0;
    end else if (wr_valid && !wr_ready && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_register_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_register_queue
// Brief    : Queue-model bench driving DEPTH=8 and DEPTH=5 instances together.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_register_queue;

  typedef logic [67:0] instr_t;

  logic        clk;
  logic        reset_en;
  logic        flush;
  logic        wr_valid;
  logic        rd_ready;
  logic [3:0]  wr_opcode;
  logic [31:0] wr_operand_a;
  logic [31:0] wr_operand_b;
  logic [2:0]  peek_index;

  logic        wr_ready8, rd_valid8, peek_valid8, full8, empty8;
  logic [3:0]  count8;
  instr_t      rd_instr8, peek_instr8;
  logic        wr_ready5, rd_valid5, peek_valid5, full5, empty5;
  logic [2:0]  count5;
  instr_t      rd_instr5, peek_instr5;
`ifdef INSTR_REG_DROP_CNT_EN
  logic [15:0] drop8, drop5;
`endif

  int checks = 0;
  int errors = 0;

  instr_t q8[$];
  instr_t q5[$];
  int     mdrop8 = 0;
  int     mdrop5 = 0;

  instr_register_queue #(.OPC_W(4), .OPD_W(32), .DEPTH(8)) dut8 (
    .clk(clk), .reset_en(reset_en), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready8),
    .wr_opcode(wr_opcode), .wr_operand_a(wr_operand_a), .wr_operand_b(wr_operand_b),
    .rd_valid(rd_valid8), .rd_ready(rd_ready), .rd_instr(rd_instr8),
    .peek_index(peek_index), .peek_instr(peek_instr8), .peek_valid(peek_valid8),
    .count(count8), .full(full8),
`ifdef INSTR_REG_DROP_CNT_EN
    .drop_count(drop8),
`endif
    .empty(empty8)
  );

  instr_register_queue #(.OPC_W(4), .OPD_W(32), .DEPTH(5)) dut5 (
    .clk(clk), .reset_en(reset_en), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready5),
    .wr_opcode(wr_opcode), .wr_operand_a(wr_operand_a), .wr_operand_b(wr_operand_b),
    .rd_valid(rd_valid5), .rd_ready(rd_ready), .rd_instr(rd_instr5),
    .peek_index(peek_index), .peek_instr(peek_instr5), .peek_valid(peek_valid5),
    .count(count5), .full(full5),
`ifdef INSTR_REG_DROP_CNT_EN
    .drop_count(drop5),
`endif
    .empty(empty5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each queue is a plain list of instructions in arrival order.
  always @(posedge clk or posedge reset_en) begin
    if (reset_en) begin
      q8.delete();
      q5.delete();
      mdrop8 = 0;
      mdrop5 = 0;
    end else begin
      automatic instr_t w = {wr_opcode, wr_operand_a, wr_operand_b};
      automatic bit push8 = wr_valid && (q8.size() < 8);
      automatic bit pop8  = rd_ready && (q8.size() > 0);
      automatic bit push5 = wr_valid && (q5.size() < 5);
      automatic bit pop5  = rd_ready && (q5.size() > 0);
      if (wr_valid && q8.size() == 8 && mdrop8 < 65535) mdrop8++;
      if (wr_valid && q5.size() == 5 && mdrop5 < 65535) mdrop5++;
      if (flush) begin
        q8.delete();
        q5.delete();
      end else begin
        if (pop8)  void'(q8.pop_front());
        if (push8) q8.push_back(w);
        if (pop5)  void'(q5.pop_front());
        if (push5) q5.push_back(w);
      end
    end
  end

  task automatic cmp_dut(input string tag, input int depth, input int cnt, input bit fl,
                         input bit em, input bit wrr, input bit rdv, input instr_t rdi,
                         input bit pv, input instr_t pki, input int pidx, input instr_t q[$]);
    chk({tag, "_count"}, cnt, q.size());
    chk({tag, "_full"}, fl, q.size() == depth);
    chk({tag, "_empty"}, em, q.size() == 0);
    chk({tag, "_wr_ready"}, wrr, q.size() != depth);
    chk({tag, "_rd_valid"}, rdv, q.size() != 0);
    if (q.size() > 0) chk({tag, "_rd_instr"}, rdi, q[0]);
    if (pidx < q.size()) begin
      chk({tag, "_peek_valid"}, pv, 1);
      chk({tag, "_peek_instr"}, pki, q[pidx]);
    end else begin
      chk({tag, "_peek_valid"}, pv, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_en) begin
      cmp_dut("d8", 8, int'(count8), full8, empty8, wr_ready8, rd_valid8, rd_instr8,
              peek_valid8, peek_instr8, int'(peek_index), q8);
      cmp_dut("d5", 5, int'(count5), full5, empty5, wr_ready5, rd_valid5, rd_instr5,
              peek_valid5, peek_instr5, int'(peek_index), q5);
`ifdef INSTR_REG_DROP_CNT_EN
      chk("d8_drop", drop8, mdrop8);
      chk("d5_drop", drop5, mdrop5);
`endif
    end
  end

  function automatic instr_t mk(input int i);
    return {4'(i), 32'(i * 10), 32'(32'hB0 + i)};
  endfunction

  function automatic instr_t rnd();
    return {4'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic drive(input bit v, input bit r, input bit f, input instr_t w);
    wr_valid = v;
    rd_ready = r;
    flush    = f;
    {wr_opcode, wr_operand_a, wr_operand_b} = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t w0, w1, w2, p[5];
    reset_en   = 1'b1;
    peek_index = '0;
    drive(0, 0, 0, '0);
    repeat (3) @(posedge clk);
    #2 reset_en = 1'b0;

    // Asynchronous reset in the middle of a cycle after three pushes
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, rnd()); tick(); end
    drive(0, 0, 0, '0);
    #1 reset_en = 1'b1;
    #1;
    chk("rst_count", count8, 0);
    chk("rst_empty", empty8, 1);
    chk("rst_rd_valid", rd_valid8, 0);
    chk("rst_wr_ready", wr_ready8, 1);
    chk("rst_rd_instr", rd_instr8, 0);
    chk("rst_peek_instr", peek_instr8, 0);
    chk("rst_count5", count5, 0);
    @(posedge clk); #2 reset_en = 1'b0;
    drive(0, 1, 0, '0); tick(); drive(0, 0, 0, '0); #1;
    chk("rst_pop_count", count8, 0);
    chk("rst_pop_empty", empty8, 1);

    // Fill, then hammer the full queue to exercise dropped pushes
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0, mk(i)); tick(); end
    drive(0, 0, 0, '0); #1;
    chk("fill_full", full8, 1);
    chk("fill_wr_ready", wr_ready8, 0);
    chk("fill_count", count8, 8);
    chk("fill_count5", count5, 5);
    drive(1, 0, 0, mk(9));
    repeat (6) tick();
    drive(0, 0, 0, '0); #1;
    chk("drop_head", rd_instr8, mk(0));
    chk("drop_count8", count8, 8);
`ifdef INSTR_REG_DROP_CNT_EN
    chk("drop_cnt6", drop8, 6);
`endif
    drive(0, 0, 1, '0); tick(); drive(0, 0, 0, '0); #1;
    chk("flush_count", count8, 0);
`ifdef INSTR_REG_DROP_CNT_EN
    chk("flush_keeps_drop", drop8, 6);
`endif

    // Refill, simultaneous push/pop while full, then drain in order
    for (int i = 0; i < 8; i++) begin drive(1, 0, 0, mk(i)); tick(); end
    chk("head0", rd_instr8, mk(0));
    drive(1, 1, 0, mk(15)); tick(); drive(0, 0, 0, '0); #1;
    chk("full_pp_count", count8, 7);
    for (int i = 1; i < 8; i++) begin
      chk("drain_order", rd_instr8, mk(i));
      drive(0, 1, 0, '0); tick();
    end
    drive(0, 0, 0, '0); #1;
    chk("drain_empty", empty8, 1);

    // Simultaneous push/pop at empty and at count 3
    w0 = rnd();
    drive(1, 1, 0, w0); tick(); drive(0, 0, 0, '0); #1;
    chk("empty_pp_count", count8, 1);
    chk("empty_pp_head", rd_instr8, w0);
    w1 = rnd();
    drive(1, 0, 0, w1); tick();
    drive(1, 0, 0, rnd()); tick();
    drive(1, 1, 0, rnd()); tick(); drive(0, 0, 0, '0); #1;
    chk("c3_pp_count", count8, 3);
    chk("c3_pp_head", rd_instr8, w1);

    // Flush wins over a concurrent push and pop
    drive(1, 0, 0, rnd()); tick();
    chk("pre_flush_count", count8, 4);
    drive(1, 1, 1, rnd()); tick(); drive(0, 0, 0, '0); #1;
    chk("flushprio_count", count8, 0);
    chk("flushprio_empty", empty8, 1);
    w2 = rnd();
    drive(1, 0, 0, w2); tick(); drive(0, 0, 0, '0); #1;
    chk("post_flush_head", rd_instr8, w2);
    chk("post_flush_count", count8, 1);
    drive(0, 0, 1, '0); tick();

    // Pointer wrap on the non-power-of-2 instance
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, rnd()); tick(); end
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, '0); tick(); end
    for (int i = 0; i < 5; i++) begin p[i] = rnd(); drive(1, 0, 0, p[i]); tick(); end
    drive(0, 0, 0, '0);
    peek_index = 3'd4;
    #1;
    chk("wrap_full5", full5, 1);
    chk("wrap_peek_valid", peek_valid5, 1);
    chk("wrap_peek4", peek_instr5, p[4]);
    drive(0, 1, 0, '0); tick(); drive(0, 0, 0, '0); #1;
    chk("wrap_count4", count5, 4);
    chk("wrap_peek_invalid", peek_valid5, 0);
    for (int i = 1; i < 5; i++) begin
      chk("wrap_order", rd_instr5, p[i]);
      drive(0, 1, 0, '0); tick();
    end
    drive(0, 0, 1, '0); tick();

    // Random traffic with phases biased toward filling and draining
    for (int n = 0; n < 3000; n++) begin
      automatic int pw = ((n / 200) % 2 == 0) ? 75 : 30;
      drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) >= pw,
            $urandom_range(0, 79) == 0, rnd());
      peek_index = 3'($urandom);
      tick();
    end
    drive(0, 0, 0, '0);

    reset_en = 1'b1;
    #1;
    chk("final_rst_count", count8, 0);
`ifdef INSTR_REG_DROP_CNT_EN
    chk("final_rst_drop", drop8, 0);
`endif
    @(posedge clk); #2 reset_en = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
